// File: rtl/fc_link.sv
// Hand-off buffer between two fc_layer stages: streams producer elements into the consumer input buffer, then pulses start.
// Optional macro FC_LINK_RELU_EN clamps negative (two's complement) elements to zero on the way through.
module fc_link #(
  parameter int datatype_size = 8,
  parameter int output_size   = 784,
  parameter int input_size    = 784,
  localparam int AW = (input_size > 1) ? $clog2(input_size) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_func_valid,
  input  logic [datatype_size-1:0] i_func_data,
  output logic                     o_next_busy,
  input  logic                     i_cons_busy,
  output logic                     o_ibuf_we,
  output logic [datatype_size-1:0] o_ibuf_wr_data,
  output logic [AW-1:0]            o_ibuf_addr,
  output logic                     o_start,
  output logic                     o_overrun
);

  generate
    if (output_size != input_size) begin : g_size_mismatch
      $error("fc_link: output_size must equal input_size");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FILL, WAIT, START} state_t;

  state_t                   r_state;
  logic [AW-1:0]            r_count;
  logic                     r_we;
  logic [AW-1:0]            r_addr;
  logic [datatype_size-1:0] r_data;
  logic                     r_start;
  logic                     r_overrun;

  logic                     w_accept;
  logic                     w_drop;
  logic                     w_last;
  logic [datatype_size-1:0] w_proc;

  assign o_next_busy = (r_state == WAIT) | (r_state == START) | i_cons_busy;
  assign w_accept    = i_func_valid & ~o_next_busy & ((r_state == IDLE) | (r_state == FILL));
  assign w_drop      = i_func_valid & o_next_busy;
  assign w_last      = (r_count == AW'(output_size - 1));

`ifdef FC_LINK_RELU_EN
  assign w_proc = i_func_data[datatype_size-1] ? '0 : i_func_data;
`else
  assign w_proc = i_func_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_start   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_we    <= w_accept;
      r_start <= 1'b0;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      // The counter wraps on the last element so the next frame starts at address 0.
      if (w_accept) begin
        r_addr <= r_count;
        r_data <= w_proc;
        if (w_last) begin
          r_count <= '0;
          r_state <= WAIT;
        end else begin
          r_count <= r_count + AW'(1);
          r_state <= FILL;
        end
      end
      case (r_state)
        WAIT: begin
          if (!i_cons_busy) begin
            r_state <= START;
            r_start <= 1'b1;
          end
        end
        START:   r_state <= IDLE;
        default: ;
      endcase
    end
  end

  assign o_ibuf_we      = r_we;
  assign o_ibuf_addr    = r_addr;
  assign o_ibuf_wr_data = r_data;
  assign o_start        = r_start;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_fc_link.sv
// Scoreboard bench for fc_link: directed fills push expected writes/start cycles, a negedge monitor checks them.
module tb_fc_link;
  localparam int DW = 8;
  localparam int N  = 784;
  localparam int AW = $clog2(N);

  logic          clk;
  logic          rst;
  logic          i_func_valid;
  logic [DW-1:0] i_func_data;
  logic          o_next_busy;
  logic          i_cons_busy;
  logic          o_ibuf_we;
  logic [DW-1:0] o_ibuf_wr_data;
  logic [AW-1:0] o_ibuf_addr;
  logic          o_start;
  logic          o_overrun;

  fc_link #(.datatype_size(DW), .output_size(N), .input_size(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_func_valid   (i_func_valid),
    .i_func_data    (i_func_data),
    .o_next_busy    (o_next_busy),
    .i_cons_busy    (i_cons_busy),
    .o_ibuf_we      (o_ibuf_we),
    .o_ibuf_wr_data (o_ibuf_wr_data),
    .o_ibuf_addr    (o_ibuf_addr),
    .o_start        (o_start),
    .o_overrun      (o_overrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_cyc;

  int          exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int          exp_start_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time bound at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
`ifdef FC_LINK_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every start pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_ibuf_we === 1'b1) begin
      n_cmp++;
      if (exp_addr_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected (cycle %0d)", o_ibuf_addr, o_ibuf_wr_data, cyc);
      end else begin
        int          ea;
        logic [DW-1:0] ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (int'(o_ibuf_addr) !== ea || o_ibuf_wr_data !== ed) begin
          n_err++;
          $display("FAIL write: got addr %0d data %0h, expected addr %0d data %0h (cycle %0d)", o_ibuf_addr, o_ibuf_wr_data, ea, ed, cyc);
        end
      end
    end
    if (o_start === 1'b1) begin
      n_cmp++;
      if (exp_start_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_start: o_start at cycle %0d, none expected", cyc);
      end else begin
        int ec;
        ec = exp_start_q.pop_front();
        if (cyc !== ec) begin
          n_err++;
          $display("FAIL start_cycle: got cycle %0d expected cycle %0d", cyc, ec);
        end else begin
          $display("ok   start pulse at cycle %0d", cyc);
        end
      end
    end
  end

  // Drives n back-to-back valid elements, indices first..first+n-1, data = index[7:0].
  task automatic fill(input int n, input int first);
    for (int i = first; i < first + n; i++) begin
      logic [DW-1:0] d;
      d = i[DW-1:0];
      i_func_valid = 1'b1;
      i_func_data  = d;
      exp_addr_q.push_back(i);
      exp_data_q.push_back(model(d));
      last_cyc = cyc;
      tick();
    end
    i_func_valid = 1'b0;
    i_func_data  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_we"},      int'(o_ibuf_we), 0);
    chk({tag, "_addr"},    int'(o_ibuf_addr), 0);
    chk({tag, "_data"},    int'(o_ibuf_wr_data), 0);
    chk({tag, "_start"},   int'(o_start), 0);
    chk({tag, "_overrun"}, int'(o_overrun), 0);
    chk({tag, "_busy"},    int'(o_next_busy), 0);
  endtask

  initial begin
    rst          = 1'b1;
    i_func_valid = 1'b0;
    i_func_data  = '0;
    i_cons_busy  = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Full frame, no back-pressure: start two cycles after last valid.
    fill(N, 0);
    exp_start_q.push_back(last_cyc + 2);
    repeat (4) tick();
    @(negedge clk);
    chk("idle_after_start_busy", int'(o_next_busy), 0);
    tick();

    // Consumer busy as the frame completes, released after 50 cycles.
    fill(N, 0);
    i_cons_busy = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("wait_hold_busy", int'(o_next_busy), 1);
      tick();
    end
    i_cons_busy = 1'b0;
    exp_start_q.push_back(cyc + 1);
    repeat (4) tick();

    // Valid offered during WAIT is dropped and latches overrun.
    fill(N, 0);
    exp_start_q.push_back(last_cyc + 2);
    i_func_valid = 1'b1;
    i_func_data  = 8'h55;
    tick();
    i_func_valid = 1'b0;
    @(negedge clk);
    chk("overrun_set", int'(o_overrun), 1);
    repeat (20) tick();
    @(negedge clk);
    chk("overrun_sticky", int'(o_overrun), 1);
    tick();

    // Reset after 300 elements: partial frame discarded, no start.
    fill(300, 0);
    rst = 1'b1;
    tick();
    chk_all_zero("midfill_reset");
    rst = 1'b0;
    repeat (3) tick();
    fill(N, 0);
    exp_start_q.push_back(last_cyc + 2);
    repeat (4) tick();

    // Consumer busy for 10 cycles at element 400; producer pauses.
    fill(400, 0);
    i_cons_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("fill_stall_busy", int'(o_next_busy), 1);
      tick();
    end
    i_cons_busy = 1'b0;
    fill(N - 400, 400);
    exp_start_q.push_back(last_cyc + 2);
    repeat (5) tick();
    @(negedge clk);
    chk("no_overrun_after_stall", int'(o_overrun), 0);

    chk("pending_writes", exp_addr_q.size(), 0);
    chk("pending_starts", exp_start_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_link.md
FC_LINK -- requirements
Module: fc_link

Interface
REQ-001 The block SHALL have parameter datatype_size, default 8: element width in bits.
REQ-002 The block SHALL have parameter output_size, default 784: element count produced by the upstream fc_layer.
REQ-003 The block SHALL have parameter input_size, default 784: downstream fc_layer input-buffer depth; output_size SHALL equal input_size, with elaboration failing otherwise.
REQ-004 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port i_func_valid, input, 1: upstream element valid strobe.
REQ-007 The block SHALL have port i_func_data, input, datatype_size: upstream element (o_func_data of the producer).
REQ-008 The block SHALL have port o_next_busy, output, 1: stall to upstream i_next_busy.
REQ-009 The block SHALL have port i_cons_busy, input, 1: downstream o_busy.
REQ-010 The block SHALL have port o_ibuf_we, output, 1: downstream input-buffer write enable.
REQ-011 The block SHALL have port o_ibuf_wr_data, output, datatype_size: downstream input-buffer write data.
REQ-012 The block SHALL have port o_ibuf_addr, output, $clog2(input_size): downstream input-buffer write address.
REQ-013 The block SHALL have port o_start, output, 1: one-cycle start pulse to downstream i_start.
REQ-014 The block SHALL have port o_overrun, output, 1: sticky flag for a dropped element.

Function
REQ-015 FSM states SHALL be IDLE, FILL, WAIT and START, encoded in a registered state variable.
REQ-016 Element acceptance SHALL occur when i_func_valid=1, o_next_busy=0 and state is IDLE or FILL.
REQ-017 o_next_busy SHALL be combinational and equal (state==WAIT)|(state==START)|i_cons_busy.
REQ-018 Each accepted element SHALL produce o_ibuf_we=1 on the next cycle, with o_ibuf_addr = word count before acceptance and o_ibuf_wr_data = processed element (REQ-029); o_ibuf_we SHALL be 0 otherwise.
REQ-019 The word counter SHALL start at 0 and increment per acceptance; addresses SHALL be strictly sequential 0..output_size-1 with no gaps.
REQ-020 The first acceptance SHALL move IDLE->FILL; for output_size=1 it SHALL go directly to WAIT.
REQ-021 Acceptance of element output_size-1 SHALL move to WAIT and wrap the counter to 0 in the same cycle.
REQ-022 In WAIT with i_cons_busy=0, the FSM SHALL move to START; o_start SHALL be 1 exactly during the START cycle; START SHALL move to IDLE unconditionally.
REQ-023 The o_start cycle SHALL follow the last o_ibuf_we by at least 1 cycle, and o_ibuf_we SHALL never assert in the START cycle.
REQ-024 In WAIT with i_cons_busy=1, the FSM SHALL hold WAIT indefinitely.
REQ-025 An element with i_func_valid=1 while o_next_busy=1 SHALL be dropped: no write, no count change, and o_overrun set to 1 from the next cycle until rst.
REQ-026 i_cons_busy rising mid-FILL SHALL stall further acceptance and SHALL preserve the counter; FILL SHALL resume when it falls.
REQ-027 Latency from acceptance to write SHALL be 1 cycle; minimum latency from last acceptance to o_start SHALL be 2 cycles.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set state=IDLE, counter=0, o_ibuf_we=0, o_ibuf_addr=0, o_ibuf_wr_data=0, o_start=0 and o_overrun=0; reset mid-FILL SHALL discard partial data and SHALL NOT emit o_start.

Configuration
REQ-029 With macro FC_LINK_RELU_EN defined, i_func_data SHALL be treated as two's complement and negative values SHALL be written as 0, other values unchanged; without the macro, data SHALL pass through unmodified and the comparator SHALL be absent.

Verification
REQ-030 Reset, then 784 back-to-back valids with data=addr[7:0] and i_cons_busy=0 -> writes to addr 0..783 with matching data, WAIT reached, o_start pulses once 2 cycles after last valid, then IDLE.
REQ-031 i_cons_busy=1 when fill completes, released after 50 cycles -> WAIT held 50 cycles, o_next_busy=1 throughout, o_start asserts 1 cycle after release.
REQ-032 valid asserted during WAIT -> no o_ibuf_we, o_overrun=1 next cycle and remaining 1 until rst.
REQ-033 rst asserted after 300 accepted elements -> all outputs 0, next fill starts at addr 0, no o_start from the aborted fill.
REQ-034 i_cons_busy pulsed for 10 cycles at element 400 -> no drops when the producer honours the stall, addresses contiguous.
REQ-035 With FC_LINK_RELU_EN defined, data 8'h80, 8'hFF, 8'h7F -> written 8'h00, 8'h00, 8'h7F; without it -> written unchanged.
